stream_mem_arbiter: RTL and testbench

STREAM_MEM_ARBITER -- requirements
Module: stream_mem_arbiter

---
 rtl/stream_mem_arbiter_pkg.sv | 15 +
 rtl/stream_fifo.sv | 78 +++++++
 rtl/stream_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_stream_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mem_arbiter_pkg.sv
// stream_mem_arbiter_pkg: width helpers shared by the arbiter and its FIFOs.
// No ports; imported with import stream_mem_arbiter_pkg::*.
package stream_mem_arbiter_pkg;

    // Bits needed to index n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to count 0..max_out inclusive, plus a guard bit.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO, optional fall-through when empty.
// Ports: clk_i, rst_i (async high), data_i/valid_i/ready_o in,
//        data_o/valid_o/ready_i out.
module stream_fifo
    import stream_mem_arbiter_pkg::*;
#(
    parameter type         T            = logic,
    parameter int unsigned Depth        = 2,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  T     data_i,
    input  logic valid_i,
    output logic ready_o,
    output T     data_o,
    output logic valid_o,
    input  logic ready_i
);

    localparam int unsigned PtrW  = idx_width(Depth);
    localparam int unsigned FillW = cnt_width(Depth);

    T                 mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [FillW-1:0] fill_q;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        empty   = (fill_q == '0);
        full    = (fill_q == FillW'(Depth));
        bypass  = FALL_THROUGH && empty;
        valid_o = !empty || (FALL_THROUGH && valid_i);
        data_o  = bypass ? data_i : mem_q[rd_ptr_q];
        // A full FIFO still takes a word when its head leaves this cycle.
        ready_o = !full || ready_i;
        push    = valid_i && ready_o;
        pop     = valid_o && ready_i;
        // A word passing straight through never touches storage.
        wr_en   = push && !(bypass && pop);
        rd_en   = pop && !bypass;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + FillW'(1);
                2'b01:   fill_q <= fill_q - FillW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

endmodule

// File: rtl/stream_mem_arbiter.sv
// stream_mem_arbiter: N requesters share one in-order memory port.
// Ports: clk_i, rst_i (async high); req_i/req_valid_i/req_ready_o,
//   resp_o/resp_valid_o/resp_ready_i per requester; mem_req_o/
//   mem_req_valid_o/mem_req_ready_i and mem_resp_i/mem_resp_valid_i.
// Build option STREAM_MEM_ARBITER_FIXED_PRIO_EN: fixed priority.
module stream_mem_arbiter
    import stream_mem_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  mem_req_t          req_i [NumReq],
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    output mem_resp_t         resp_o,
    output logic [NumReq-1:0] resp_valid_o,
    input  logic [NumReq-1:0] resp_ready_i,
    output mem_req_t          mem_req_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    input  mem_resp_t         mem_resp_i,
    input  logic              mem_resp_valid_i
);

    localparam int unsigned IdxW = idx_width(NumReq);
    localparam int unsigned CntW = cnt_width(MaxOutstanding);

    typedef logic [IdxW-1:0] idx_t;

    idx_t            grant;
    idx_t            arb_idx;
    idx_t            lock_idx_q;
    idx_t            id_head;
    logic            lock_q;
    logic [CntW-1:0] cnt_q;

    logic issue_ok;
    logic req_hs;
    logic resp_hs;
    logic id_valid;
    logic id_in_ready;
    logic rsp_valid;
    logic rsp_in_ready;

`ifdef STREAM_MEM_ARBITER_FIXED_PRIO_EN
    always_comb begin
        arb_idx = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i]) arb_idx = idx_t'(i);
        end
    end
`else
    idx_t rr_ptr_q;

    // Scan offsets from far to near so the nearest valid one wins.
    always_comb begin
        int c;
        c       = 0;
        arb_idx = rr_ptr_q;
        for (int i = NumReq - 1; i >= 0; i--) begin
            c = int'(rr_ptr_q) + i;
            if (c >= int'(NumReq)) c = c - int'(NumReq);
            if (req_valid_i[c]) arb_idx = idx_t'(c);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (req_hs) begin
            rr_ptr_q <= (grant == idx_t'(NumReq - 1)) ? '0
                                                      : grant + idx_t'(1);
        end
    end
`endif

    always_comb begin
        grant        = lock_q ? lock_idx_q : arb_idx;
        resp_hs      = !rst_i && id_valid && rsp_valid
                       && resp_ready_i[id_head];
        // A response leaving this cycle frees a slot for a new request.
        issue_ok     = (cnt_q < CntW'(MaxOutstanding)) || resp_hs;
        mem_req_o    = req_i[grant];
        mem_req_valid_o = !rst_i && (|req_valid_i) && issue_ok;
        req_hs       = mem_req_valid_o && mem_req_ready_i;
        req_ready_o  = '0;
        if (!rst_i && issue_ok && mem_req_ready_i) begin
            req_ready_o[grant] = 1'b1;
        end
        resp_valid_o = '0;
        if (!rst_i && id_valid && rsp_valid) begin
            resp_valid_o[id_head] = 1'b1;
        end
    end

    // An offered but unaccepted request pins the grant until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= mem_req_valid_o && !mem_req_ready_i;
            lock_idx_q <= grant;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            unique case ({req_hs, resp_hs})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    stream_fifo #(
        .T            (idx_t),
        .Depth        (MaxOutstanding),
        .FALL_THROUGH (1'b0)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (grant),
        .valid_i (req_hs),
        .ready_o (id_in_ready),
        .data_o  (id_head),
        .valid_o (id_valid),
        .ready_i (resp_hs)
    );

    stream_fifo #(
        .T            (mem_resp_t),
        .Depth        (MaxOutstanding),
        .FALL_THROUGH (1'b1)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (mem_resp_i),
        .valid_i (mem_resp_valid_i),
        .ready_o (rsp_in_ready),
        .data_o  (resp_o),
        .valid_o (rsp_valid),
        .ready_i (resp_hs)
    );

`ifndef SYNTHESIS
    a_resp_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_resp_valid_i |-> rsp_in_ready);
    a_id_room: assert property (@(posedge clk_i) disable iff (rst_i)
        req_hs |-> id_in_ready);
    a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_q <= CntW'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_stream_mem_arbiter.sv
// tb_stream_mem_arbiter: directed bench for stream_mem_arbiter.
// In-order memory model with programmable latency; data = req ^ 8'h5A.
module tb_stream_mem_arbiter;

`ifdef STREAM_MEM_ARBITER_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    // Expectations for the second grant of a pair (requester 1 in RR).
    localparam logic [1:0] RDY_B = FP ? 2'b01 : 2'b10;
    localparam logic [1:0] VLD_B = FP ? 2'b01 : 2'b10;
    localparam logic [7:0] REQ_B = FP ? 8'h10 : 8'h21;
    localparam logic [7:0] RSP_B = FP ? 8'h4A : 8'h7B;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req [2];
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] resp;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    logic [7:0] mem_req;
    logic       mem_req_valid;
    logic       mem_req_ready;
    logic [7:0] mem_resp = 8'h00;
    logic       mem_resp_valid = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mq_data [$];
    int         mq_due [$];
    int         cyc = 0;
    int         lat = 1;

    always #5 clk = ~clk;

    stream_mem_arbiter #(
        .NumReq         (2),
        .MaxOutstanding (2),
        .mem_req_t      (logic [7:0]),
        .mem_resp_t     (logic [7:0])
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .mem_req_o        (mem_req),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_resp_i       (mem_resp),
        .mem_resp_valid_i (mem_resp_valid)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq_data.delete();
            mq_due.delete();
        end else if (mem_req_valid && mem_req_ready) begin
            mq_data.push_back(mem_req);
            mq_due.push_back(cyc + lat);
        end
    end

    always @(negedge clk) begin
        if (!rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            mem_resp_valid <= 1'b1;
            mem_resp       <= mq_data[0] ^ 8'h5A;
            void'(mq_data.pop_front());
            void'(mq_due.pop_front());
        end else begin
            mem_resp_valid <= 1'b0;
            mem_resp       <= 8'h00;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst           = 1'b1;
        req_valid     = 2'b00;
        mem_req_ready = 1'b0;
        resp_ready    = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_total++;
        if (req_ready !== 2'b00)
            $display("FAIL reset_req_ready got=%b exp=00", req_ready);
        else n_pass++;
        n_total++;
        if (mem_req_valid !== 1'b0)
            $display("FAIL reset_mem_valid got=%b exp=0", mem_req_valid);
        else n_pass++;
        n_total++;
        if (resp_valid !== 2'b00)
            $display("FAIL reset_resp_valid got=%b exp=00", resp_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] e_rdy;
        logic [1:0] e_vld;
        logic [7:0] e_req;
        logic [7:0] e_rsp;
        bit         even;
        apply_reset();
        lat           = 1;
        mem_req_ready = 1'b1;
        resp_ready    = 2'b11;
        req_valid     = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            even  = (c % 2 == 0);
            e_rdy = even ? 2'b01 : RDY_B;
            e_req = even ? 8'h10 : REQ_B;
            e_vld = (c == 0) ? 2'b00 : (even ? VLD_B : 2'b01);
            e_rsp = even ? RSP_B : 8'h4A;
            n_total++;
            if (req_ready !== e_rdy)
                $display("FAIL rr_ready c=%0d got=%b exp=%b",
                         c, req_ready, e_rdy);
            else n_pass++;
            n_total++;
            if (mem_req !== e_req)
                $display("FAIL rr_mem_req c=%0d got=%h exp=%h",
                         c, mem_req, e_req);
            else n_pass++;
            n_total++;
            if (resp_valid !== e_vld)
                $display("FAIL rr_resp_valid c=%0d got=%b exp=%b",
                         c, resp_valid, e_vld);
            else n_pass++;
            if (c > 0) begin
                n_total++;
                if (resp !== e_rsp)
                    $display("FAIL rr_resp c=%0d got=%h exp=%h",
                             c, resp, e_rsp);
                else n_pass++;
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_outstanding();
        logic [1:0] e_rdy [5];
        logic [1:0] e_vld [5];
        logic [7:0] e_rsp [5];
        e_rdy = '{2'b01, RDY_B, 2'b00, 2'b01, RDY_B};
        e_vld = '{2'b00, 2'b00, 2'b00, 2'b01, VLD_B};
        e_rsp = '{8'h00, 8'h00, 8'h00, 8'h4A, RSP_B};
        apply_reset();
        lat           = 3;
        mem_req_ready = 1'b1;
        resp_ready    = 2'b11;
        req_valid     = 2'b11;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_total++;
            if (req_ready !== e_rdy[c])
                $display("FAIL out_ready c=%0d got=%b exp=%b",
                         c, req_ready, e_rdy[c]);
            else n_pass++;
            n_total++;
            if (resp_valid !== e_vld[c])
                $display("FAIL out_resp_valid c=%0d got=%b exp=%b",
                         c, resp_valid, e_vld[c]);
            else n_pass++;
            if (c == 2) begin
                n_total++;
                if (mem_req_valid !== 1'b0)
                    $display("FAIL out_stall_valid got=%b exp=0",
                             mem_req_valid);
                else n_pass++;
            end
            if (c >= 3) begin
                n_total++;
                if (resp !== e_rsp[c])
                    $display("FAIL out_resp c=%0d got=%h exp=%h",
                             c, resp, e_rsp[c]);
                else n_pass++;
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_hold();
        apply_reset();
        lat           = 1;
        mem_req_ready = 1'b1;
        resp_ready    = 2'b11;
        req_valid     = 2'b01;
        @(negedge clk);
        req_valid     = 2'b00;
        mem_req_ready = 1'b0;
        @(negedge clk);
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) req_valid = 2'b11;
            #1;
            n_total++;
            if (mem_req !== 8'h10 || mem_req_valid !== 1'b1)
                $display("FAIL hold_mem_req c=%0d got=%h/%b exp=10/1",
                         c, mem_req, mem_req_valid);
            else n_pass++;
            n_total++;
            if (req_ready !== 2'b00)
                $display("FAIL hold_ready c=%0d got=%b exp=00",
                         c, req_ready);
            else n_pass++;
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 2'b01 || mem_req !== 8'h10)
            $display("FAIL hold_release got=%b/%h exp=01/10",
                     req_ready, mem_req);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (req_ready !== RDY_B || mem_req !== REQ_B)
            $display("FAIL hold_next got=%b/%h exp=%b/%h",
                     req_ready, mem_req, RDY_B, REQ_B);
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_head_of_line();
        logic [1:0] e_vld [8];
        logic [7:0] e_rsp [8];
        e_vld = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                  2'b01, VLD_B, 2'b00};
        e_rsp = '{8'h4A, 8'h4A, 8'h4A, 8'h4A, 8'h4A,
                  8'h4A, RSP_B, 8'h00};
        apply_reset();
        lat           = 1;
        mem_req_ready = 1'b1;
        resp_ready    = 2'b10;
        req_valid     = 2'b11;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) req_valid = 2'b00;
            if (c == 6) resp_ready = 2'b11;
            #1;
            n_total++;
            if (resp_valid !== e_vld[c - 1])
                $display("FAIL hol_resp_valid c=%0d got=%b exp=%b",
                         c, resp_valid, e_vld[c - 1]);
            else n_pass++;
            if (c < 7) begin
                n_total++;
                if (resp !== e_rsp[c - 1])
                    $display("FAIL hol_resp c=%0d got=%h exp=%h",
                             c, resp, e_rsp[c - 1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        lat           = 3;
        mem_req_ready = 1'b1;
        resp_ready    = 2'b11;
        req_valid     = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 2'b00 || mem_req_valid !== 1'b0
            || resp_valid !== 2'b00)
            $display("FAIL mid_rst_outputs got=%b/%b/%b exp=00/0/00",
                     req_ready, mem_req_valid, resp_valid);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (req_ready !== 2'b00 || mem_req_valid !== 1'b0)
            $display("FAIL mid_rst_hold got=%b/%b exp=00/0",
                     req_ready, mem_req_valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (req_ready !== 2'b01 || mem_req !== 8'h10)
            $display("FAIL mid_after_first got=%b/%h exp=01/10",
                     req_ready, mem_req);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (req_ready !== RDY_B || mem_req !== REQ_B)
            $display("FAIL mid_after_second got=%b/%h exp=%b/%h",
                     req_ready, mem_req, RDY_B, REQ_B);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (req_ready !== 2'b00)
            $display("FAIL mid_after_full got=%b exp=00", req_ready);
        else n_pass++;
        req_valid = 2'b00;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        req[0]        = 8'h10;
        req[1]        = 8'h21;
        req_valid     = 2'b11;
        mem_req_ready = 1'b1;
        resp_ready    = 2'b11;
        test_reset();
        test_round_robin();
        test_outstanding();
        test_hold();
        test_head_of_line();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
